// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display path.
package display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    function automatic seg_t seg_mask(input seg_t pattern, input logic blank);
        return blank ? SEG_BLANK : pattern;
    endfunction

endpackage

// File: rtl/button_event.sv
// Raw button to one-cycle rising-edge event: 2-flop synchronizer, optional counter filter
// (enabled by defining DEBOUNCE_EN), edge detect gated while the pipeline refills after reset.
module button_event #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_rise
);

`ifdef DEBOUNCE_EN
    localparam int unsigned FILTER_LAT = DEBOUNCE_CYCLES;
`else
    // No filter in this build; the parameter only keeps the interface uniform.
    localparam int unsigned FILTER_LAT = 0 * DEBOUNCE_CYCLES;
`endif
    // Edges until a level held through reset has reached r_prev.
    localparam int unsigned ARM_LEN = FILTER_LAT + 3;
    localparam int unsigned AW      = $clog2(ARM_LEN + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    logic [AW-1:0] r_arm;
    logic          w_level;
    logic          w_armed;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_arm   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_prev  <= w_level;
            if (!w_armed) begin
                r_arm <= r_arm + AW'(1);
            end
        end
    end

`ifdef DEBOUNCE_EN
    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          r_filt;
    logic [DW-1:0] r_dcnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_filt <= 1'b0;
            r_dcnt <= '0;
        end else if (r_sync2 == r_filt) begin
            r_dcnt <= '0;
        end else if (r_dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            r_filt <= r_sync2;
            r_dcnt <= '0;
        end else begin
            r_dcnt <= r_dcnt + DW'(1);
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync2;
`endif

    assign w_armed = (r_arm == AW'(ARM_LEN));
    assign o_rise  = w_level & ~r_prev & w_armed;

endmodule

// File: rtl/display_blink_scheduler.sv
// Digit scan, blink timebase and edit cursor for a multiplexed 7-segment display.
// Define DEBOUNCE_EN to add a counter filter on each button.
module display_blink_scheduler
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS      = 4,
    parameter int unsigned SCAN_DIV        = 50_000,
    parameter int unsigned BLINK_DIV       = 12_500_000,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          edit_en,
    input  logic                          btn_left,
    input  logic                          btn_right,
    input  logic [7*NUM_DIGITS-1:0]       digit_seg,
    output logic [NUM_DIGITS-1:0]         anode_n,
    output seg_t                          seg_n,
    output logic [$clog2(NUM_DIGITS)-1:0] cursor,
    output logic                          blink_pulse
);

    localparam int unsigned CW = $clog2(NUM_DIGITS);
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [SW-1:0]         r_scan_cnt;
    logic [CW-1:0]         r_scan_idx;
    logic [BW-1:0]         r_blink_cnt;
    logic                  r_blank_phase;
    logic                  r_blink_pulse;
    logic [CW-1:0]         r_cursor;
    logic [NUM_DIGITS-1:0] r_anode_n;
    seg_t                  r_seg_n;

    seg_t                  w_digit [NUM_DIGITS];
    logic                  w_left_ev;
    logic                  w_right_ev;
    logic                  w_scan_wrap;
    logic                  w_blink_wrap;
    logic                  w_blank;
    logic [CW-1:0]         w_cursor_next;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign w_digit[gi] = digit_seg[7*gi +: 7];
    end

    button_event #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_left (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_btn   (btn_left),
        .o_rise  (w_left_ev)
    );

    button_event #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_right (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_btn   (btn_right),
        .o_rise  (w_right_ev)
    );

    assign w_scan_wrap  = (r_scan_cnt == SW'(SCAN_DIV - 1));
    assign w_blink_wrap = (r_blink_cnt == BW'(BLINK_DIV - 1));
    assign w_blank      = edit_en & r_blank_phase & (r_scan_idx == r_cursor);

    // Simultaneous left/right events cancel; events outside edit mode are dropped.
    always_comb begin
        w_cursor_next = r_cursor;
        if (edit_en && w_left_ev && !w_right_ev) begin
            w_cursor_next = (r_cursor == '0) ? CW'(NUM_DIGITS - 1) : r_cursor - CW'(1);
        end else if (edit_en && w_right_ev && !w_left_ev) begin
            w_cursor_next = (r_cursor == CW'(NUM_DIGITS - 1)) ? '0 : r_cursor + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scan_cnt    <= '0;
            r_scan_idx    <= '0;
            r_blink_cnt   <= '0;
            r_blank_phase <= 1'b0;
            r_blink_pulse <= 1'b0;
            r_cursor      <= '0;
            r_anode_n     <= '1;
            r_seg_n       <= SEG_BLANK;
        end else begin
            if (w_scan_wrap) begin
                r_scan_cnt <= '0;
                r_scan_idx <= (r_scan_idx == CW'(NUM_DIGITS - 1)) ? '0 : r_scan_idx + CW'(1);
            end else begin
                r_scan_cnt <= r_scan_cnt + SW'(1);
            end

            if (!edit_en) begin
                r_blink_cnt   <= '0;
                r_blank_phase <= 1'b0;
                r_blink_pulse <= 1'b0;
            end else if (w_blink_wrap) begin
                r_blink_cnt   <= '0;
                r_blank_phase <= ~r_blank_phase;
                r_blink_pulse <= 1'b1;
            end else begin
                r_blink_cnt   <= r_blink_cnt + BW'(1);
                r_blink_pulse <= 1'b0;
            end

            r_cursor  <= w_cursor_next;
            r_anode_n <= ~(NUM_DIGITS'(1) << r_scan_idx);
            r_seg_n   <= seg_mask(w_digit[r_scan_idx], w_blank);
        end
    end

    assign anode_n     = r_anode_n;
    assign seg_n       = r_seg_n;
    assign cursor      = r_cursor;
    assign blink_pulse = r_blink_pulse;

endmodule

// File: tb/tb_display_blink_scheduler.sv
// Directed plus randomized bench for display_blink_scheduler against a cycle-count reference model.
module tb_display_blink_scheduler;

    localparam int NUM   = 4;
    localparam int SDIV  = 2;
    localparam int BDIV  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        edit_en = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic [27:0] digit_seg = {7'h30, 7'h24, 7'h79, 7'h40};
    logic [3:0]  anode_n;
    logic [6:0]  seg_n;
    logic [1:0]  cursor;
    logic        blink_pulse;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: m_k = edges since reset release, m_e = consecutive edit-mode edges,
    // m_hl/m_hr = last three sampled button levels (bit0 newest).
    int         m_k, m_e, m_cur;
    logic [2:0] m_hl, m_hr;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_pulse;
    logic [1:0] exp_cur;

    display_blink_scheduler #(
        .NUM_DIGITS      (NUM),
        .SCAN_DIV        (SDIV),
        .BLINK_DIV       (BDIV),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .edit_en     (edit_en),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .digit_seg   (digit_seg),
        .anode_n     (anode_n),
        .seg_n       (seg_n),
        .cursor      (cursor),
        .blink_pulse (blink_pulse)
    );

    always #5 clk = ~clk;

    function automatic int idx_of(input int k);
        return (k / SDIV) % NUM;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        int   pi;
        logic ph, l, r;
        if (!rst_n) begin
            m_k = 0; m_e = 0; m_cur = 0; m_hl = '0; m_hr = '0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_pulse = 1'b0; exp_cur = 2'd0;
            return;
        end
        pi = idx_of(m_k);
        ph = ((m_e / BDIV) % 2) == 1;
        exp_an  = ~(4'b0001 << pi);
        exp_seg = digit_seg[7*pi +: 7];
        if (edit_en && ph && pi == m_cur) exp_seg = 7'h7F;
        // A rise needs 2 edges to cross the synchronizer and is ignored until 3 edges after release.
        if (edit_en && m_k + 1 >= 4) begin
            l = m_hl[1] & ~m_hl[2];
            r = m_hr[1] & ~m_hr[2];
            if (l && !r) m_cur = (m_cur + NUM - 1) % NUM;
            else if (r && !l) m_cur = (m_cur + 1) % NUM;
        end
        m_hl = {m_hl[1:0], btn_left};
        m_hr = {m_hr[1:0], btn_right};
        m_k++;
        m_e = edit_en ? m_e + 1 : 0;
        exp_pulse = edit_en && (m_e % BDIV == 0);
        exp_cur = 2'(m_cur);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("anode_n", 32'(anode_n), 32'(exp_an));
        chk("seg_n", 32'(seg_n), 32'(exp_seg));
        chk("cursor", 32'(cursor), 32'(exp_cur));
        chk("blink_pulse", 32'(blink_pulse), 32'(exp_pulse));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_btn(input logic l, input logic r);
        btn_left = l; btn_right = r;
        tick();
        btn_left = 1'b0; btn_right = 1'b0;
        ticks(4);
    endtask

    initial begin
        int pulses, blank0, blank_other;
        logic found;

        // Reset state
        ticks(2);
        chk("rst_anode", 32'(anode_n), 32'hF);
        chk("rst_seg", 32'(seg_n), 32'h7F);
        chk("rst_cursor", 32'(cursor), 32'd0);
        chk("rst_pulse", 32'(blink_pulse), 32'd0);

        // Scan with edit disabled
        rst_n = 1'b1;
        tick();
        chk("scan_first_anode", 32'(anode_n), 32'hE);
        chk("scan_first_seg", 32'(seg_n), 32'h40);
        ticks(2);
        chk("scan_d1_anode", 32'(anode_n), 32'hD);
        chk("scan_d1_seg", 32'(seg_n), 32'h79);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (blink_pulse) pulses++;
        end
        chk("no_pulse_edit_off", 32'(pulses), 32'd0);

        // Blink with cursor on digit 0
        edit_en = 1'b1;
        pulses = 0; blank0 = 0; blank_other = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (blink_pulse) pulses++;
            if (seg_n == 7'h7F && anode_n == 4'hE) blank0++;
            if (seg_n == 7'h7F && anode_n != 4'hE) blank_other++;
        end
        chk("pulse_count_16", 32'(pulses), 32'd4);
        chk("digit0_blanked", 32'(blank0 > 0), 32'd1);
        chk("others_lit", 32'(blank_other), 32'd0);

        // Held right button: one move on the 3rd edge
        btn_right = 1'b1;
        tick(); chk("lat_e1", 32'(cursor), 32'd0);
        tick(); chk("lat_e2", 32'(cursor), 32'd0);
        tick(); chk("lat_e3", 32'(cursor), 32'd1);
        ticks(7);
        chk("held_once", 32'(cursor), 32'd1);
        btn_right = 1'b0;
        ticks(8);

        // Wrap in both directions
        pulse_btn(1'b1, 1'b0); chk("left_to0", 32'(cursor), 32'd0);
        pulse_btn(1'b1, 1'b0); chk("left_wrap", 32'(cursor), 32'd3);
        pulse_btn(1'b0, 1'b1); chk("right_wrap", 32'(cursor), 32'd0);

        // Simultaneous events and edit-off events are discarded
        pulse_btn(1'b1, 1'b1); chk("both_nomove", 32'(cursor), 32'd0);
        edit_en = 1'b0;
        pulse_btn(1'b0, 1'b1); chk("edit_off_nomove", 32'(cursor), 32'd0);
        edit_en = 1'b1;
        ticks(2);
        chk("edit_off_not_queued", 32'(cursor), 32'd0);

        // Reset while blanking with right button held
        btn_right = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (((m_e / BDIV) % 2) == 1 && idx_of(m_k) == m_cur && m_k > 8) found = 1'b1;
        end
        chk("blank_window_found", 32'(found), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("midrst_anode", 32'(anode_n), 32'hF);
        chk("midrst_seg", 32'(seg_n), 32'h7F);
        chk("midrst_cursor", 32'(cursor), 32'd0);
        rst_n = 1'b1;
        ticks(10);
        chk("held_through_reset", 32'(cursor), 32'd0);
        btn_right = 1'b0;
        ticks(4);

        // Randomized operation against the model
        for (int i = 0; i < 2000; i++) begin
            tick();
            rst_n     = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 39) == 0) edit_en = ~edit_en;
            btn_left  = ($urandom_range(0, 5) == 0);
            btn_right = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) digit_seg = 28'($urandom);
        end
        ticks(2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
